burst_mem: RTL
==============

# burst_mem

Parametrised unified instruction/data memory for the pipelined MIPS core, the successor to the fixed-size 4/8-word memory model. It maps a configurable window of the 32-bit byte address space (default base 0x8002_0000) onto a word array, serves single byte/halfword/word accesses with one-cycle read latency, and runs variable-length incrementing bursts of 1..MAX_BURST words under a busy handshake. It adds alignment and range checking with an error pulse, sign-/zero-extended sub-word reads, and a defined reset state for all control outputs.

## Interface
- DEPTH_WORDS, 524288: number of 32-bit words; power of two ≥ MAX_BURST.
- BASE_ADDR, 32'h8002_0000: byte address of word 0; word-aligned.
- MAX_BURST, 8: maximum beats per burst; power of two, 2..16.
- INIT_FILE, "": hex file loaded into the array at time 0 via $readmemh; empty string means no load.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  request valid; accepted only when req=1 and busy=0.
- rd_wr  in  1  1 = read, 0 = write.
- size  in  2  0 = byte, 1 = halfword, 2 = word, 3 = burst.
- burst_len  in  $clog2(MAX_BURST)  beats minus one; sampled only on an accepted burst.
- sign_ext  in  1  sub-word reads: 1 = sign-extend, 0 = zero-extend.
- addr  in  32  byte address.
- wdata  in  32  write data; sub-word data in LSBs.
- rdata  out  32  read data.
- rvalid  out  1  rdata is valid this cycle.
- busy  out  1  burst in progress; requests ignored.
- err  out  1  one-cycle pulse: rejected request.

## Operation
- Offset off = addr − BASE_ADDR; word index = off[31:2]; lane = off[1:0].
- Lanes are big-endian: lane 0 = bits 31:24, lane 3 = bits 7:0; halfword lane 0 = 31:16, lane 2 = 15:0.
- Checks on accept, in order: misaligned (halfword with lane[0]=1; word/burst with lane≠0), out of range (addr < BASE_ADDR, or last touched word index ≥ DEPTH_WORDS; for bursts the last word is index+burst_len). On failure: err=1 the next cycle, no array access, no rvalid, state stays IDLE.
- Byte/halfword write: only the addressed lane(s) are updated; other bytes are preserved. Word write replaces the whole word.
- Sub-word read: the selected lane is right-justified into rdata, and upper bits are filled per sign_ext.
- FSM: IDLE, BURST. An accepted valid burst loads beat counter = burst_len and the word pointer. BURST → IDLE after the final beat. A burst_len of 0 is a single-word burst that never enters BURST.
- Burst write beat k takes wdata in the cycle accept+k. The producer presents the next word each cycle while busy=1.
- Burst addresses increment by one word per beat; there is no wrap.
- Requests with busy=1 are dropped, not queued, and raise no err.

## Timing
- Reset (rst_n=0, async): rdata=0, rvalid=0, busy=0, err=0, FSM=IDLE, counters cleared. Array contents are untouched.
- Single read accepted at edge t: rdata/rvalid valid in cycle t+1 (after edge t). rvalid=0 in every cycle without a completing read beat; rdata holds its last value.
- Single write: array updated at the accepting edge; a read of the same word in the next cycle returns the new data.
- Burst of N=burst_len+1 beats accepted at edge t: busy=1 in cycles t+1..t+N−1. Read beat k appears in cycle t+1+k with rvalid=1. A new request is accepted at edge t+N, giving back-to-back streams with no bubble.
- busy is driven from registered state only. No combinational path from req to busy.
- Reset asserted mid-burst: remaining beats are dropped. Words already written keep their values, and outputs go to reset values immediately.

## Test plan
- Write word 0xDEADBEEF @0x8002_0010, then read word at the same address → rvalid=1 one cycle after accept, rdata=0xDEADBEEF.
- Byte write 0x5A @0x8002_0011 over 0xDEADBEEF → word reads 0xDE5ABEEF. Byte read @0x8002_0011 with sign_ext=0 → 0x0000005A. Halfword read @0x8002_0012 with sign_ext=1 → 0xFFFFBEEF.
- Burst write, burst_len=7, @0x8002_0100, data 1..8 → busy high 7 cycles. Burst read from the same address → rvalid for 8 consecutive cycles, data 1..8. A req issued mid-burst is ignored.
- Halfword @0x8002_0001, word @0x8002_0002, and read @0x8001_FFFC → err=1 for one cycle each, no rvalid, memory unchanged.
- Burst with burst_len=3 whose last word is index DEPTH_WORDS → err, and no beat is written.
- rst_n low after beat 2 of an 8-beat write → busy/rvalid drop at once. Beats 0–2 are stored; beats 3–7 keep their old contents. The first request after reset is accepted normally.

Source files
------------

// File: rtl/burst_mem.sv
// Unified instruction/data memory for the pipelined MIPS core: a windowed word
// array serving byte/halfword/word accesses and incrementing bursts.
module burst_mem #(
  parameter int unsigned DEPTH_WORDS = 524288,
  parameter logic [31:0] BASE_ADDR   = 32'h8002_0000,
  parameter int unsigned MAX_BURST   = 8,
  parameter string       INIT_FILE   = ""
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req,
  input  logic                         rd_wr,
  input  logic [1:0]                   size,
  input  logic [$clog2(MAX_BURST)-1:0] burst_len,
  input  logic                         sign_ext,
  input  logic [31:0]                  addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata,
  output logic                         rvalid,
  output logic                         busy,
  output logic                         err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned LW = $clog2(MAX_BURST);

  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_HALF  = 2'd1;
  localparam logic [1:0] SZ_WORD  = 2'd2;
  localparam logic [1:0] SZ_BURST = 2'd3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  logic [31:0] mem_q [DEPTH_WORDS];

  state_e        state_q, state_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          dir_q, dir_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;

  logic [31:0]   off_c;
  logic [1:0]    lane_c;
  logic [31:0]   idx_c;
  logic [31:0]   last_c;
  logic          misalign_c;
  logic          range_c;
  logic          bad_c;
  logic          accept_c;
  logic [AW-1:0] ridx_c;
  logic [31:0]   rword_c;
  logic [7:0]    byte_c;
  logic [15:0]   half_c;
  logic [31:0]   rd_fmt_c;
  logic          we_c;
  logic [AW-1:0] widx_c;
  logic [3:0]    wbe_c;
  logic [31:0]   wword_c;

  // Request decode and acceptance checks.
  always_comb begin : req_check
    off_c      = addr - BASE_ADDR;
    lane_c     = off_c[1:0];
    idx_c      = {2'b00, off_c[31:2]};
    last_c     = idx_c + ((size == SZ_BURST) ? 32'(burst_len) : 32'd0);
    misalign_c = ((size == SZ_HALF) && lane_c[0]) || (size[1] && (lane_c != 2'd0));
    range_c    = (addr < BASE_ADDR) || (last_c >= 32'(DEPTH_WORDS));
    bad_c      = misalign_c || range_c;
    accept_c   = req && rst_n && (state_q == ST_IDLE);
  end

  // Big-endian lane extraction, right-justified and extended.
  always_comb begin : read_format
    ridx_c  = (state_q == ST_BURST) ? ptr_q : idx_c[AW-1:0];
    rword_c = mem_q[ridx_c];
    byte_c  = 8'(rword_c >> {~lane_c, 3'b000});
    half_c  = 16'(rword_c >> {~lane_c[1], 4'b0000});
    case (size)
      SZ_BYTE: rd_fmt_c = {{24{sign_ext & byte_c[7]}}, byte_c};
      SZ_HALF: rd_fmt_c = {{16{sign_ext & half_c[15]}}, half_c};
      default: rd_fmt_c = rword_c;
    endcase
  end

  always_comb begin : fsm_next
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    dir_d    = dir_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    we_c     = 1'b0;
    widx_c   = ptr_q;
    wbe_c    = 4'h0;
    wword_c  = wdata;
    case (state_q)
      ST_IDLE: begin
        if (accept_c && bad_c) begin
          err_d = 1'b1;
        end else if (accept_c) begin
          if (rd_wr) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_fmt_c;
          end else begin
            we_c   = 1'b1;
            widx_c = idx_c[AW-1:0];
            case (size)
              SZ_BYTE: begin
                wbe_c   = 4'b1000 >> lane_c;
                wword_c = {4{wdata[7:0]}};
              end
              SZ_HALF: begin
                wbe_c   = lane_c[1] ? 4'b0011 : 4'b1100;
                wword_c = {2{wdata[15:0]}};
              end
              default: wbe_c = 4'hF;
            endcase
          end
          // Beat 0 is served at accept; a one-beat burst never leaves IDLE.
          if ((size == SZ_BURST) && (burst_len != '0)) begin
            state_d = ST_BURST;
            cnt_d   = burst_len;
            ptr_d   = idx_c[AW-1:0] + AW'(1);
            dir_d   = rd_wr;
          end
        end
      end
      ST_BURST: begin
        if (dir_q) begin
          rvalid_d = 1'b1;
          rdata_d  = rword_c;
        end else begin
          we_c  = 1'b1;
          wbe_c = 4'hF;
        end
        ptr_d = ptr_q + AW'(1);
        cnt_d = cnt_q - LW'(1);
        if (cnt_q == LW'(1)) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin : ctrl_regs
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      dir_q    <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      dir_q    <= dir_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // Array is not reset; byte enables preserve untouched lanes.
  always_ff @(posedge clk) begin : mem_write
    if (we_c) begin
      for (int b = 0; b < 4; b++) begin
        if (wbe_c[b]) begin
          mem_q[widx_c][8*b +: 8] <= wword_c[8*b +: 8];
        end
      end
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign busy   = (state_q == ST_BURST);
  assign err    = err_q;

endmodule
